// File: rtl/ahb_arbiter16_if.sv
// Arbitration signal bundle for the 16-master AHB arbiter.
// The slave modport is the arbiter's view; the master modport is the bus/requester view.
interface ahb_arbiter16_if;
    logic [15:0] HBUSREQx;
    logic [15:0] HLOCKx;
    logic [15:0] HSPLIT;
    logic        HREADY;
    logic [15:0] HGRANTx;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;
    logic [3:0]  dbg_last;
    logic [7:0]  dbg_hold_cnt;

    modport slave (
        input  HBUSREQx, HLOCKx, HSPLIT, HREADY,
        output HGRANTx, HMASTER, HMASTLOCK, dbg_last, dbg_hold_cnt
    );

    modport master (
        output HBUSREQx, HLOCKx, HSPLIT, HREADY,
        input  HGRANTx, HMASTER, HMASTLOCK, dbg_last, dbg_hold_cnt
    );
endinterface

// File: rtl/ahb_arbiter16.sv
// Round-robin AHB arbiter for 16 masters with lock, split-release priority and a
// per-tenure hold limit. Grant, HMASTER and HMASTLOCK are all registered.
module ahb_arbiter16 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_arbiter16_if.slave bus
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [15:0] grant_q, grant_d;
    logic [3:0]  master_q, master_d;
    logic        mastlock_q, mastlock_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        owner_vld;
    logic [3:0]  owner_idx;
    logic        split_found, rr_found;
    logic [3:0]  split_idx, rr_idx, scan_idx;

    assign owner_vld = |grant_q;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (grant_q[i]) owner_idx = 4'(i);
        end
    end

    // Scan from last+16 down to last+1 so the final hit is the first in round-robin order.
    always_comb begin
        split_found = 1'b0;
        rr_found    = 1'b0;
        split_idx   = '0;
        rr_idx      = '0;
        scan_idx    = '0;
        for (int k = 16; k >= 1; k--) begin
            scan_idx = last_q + 4'(k);
            if (bus.HBUSREQx[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
            if (bus.HBUSREQx[scan_idx] && bus.HSPLIT[scan_idx]) begin
                split_found = 1'b1;
                split_idx   = scan_idx;
            end
        end
    end

    // HREADY is the only arbitration point: with HREADY low every register holds;
    // with HREADY high grant, owner info, pointer and counter advance together.
    always_comb begin
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (bus.HREADY) begin
            master_d   = owner_idx;
            mastlock_d = owner_vld && bus.HLOCKx[owner_idx];
            if (owner_vld && bus.HLOCKx[owner_idx] && bus.HBUSREQx[owner_idx]) begin
                grant_d = grant_q;
            end else if (owner_vld && bus.HBUSREQx[owner_idx] && (cnt_q < HOLD_LIMIT)) begin
                grant_d = grant_q;
                cnt_d   = cnt_q + 8'd1;
            end else if (split_found) begin
                grant_d = 16'(1) << split_idx;
                last_d  = split_idx;
                cnt_d   = '0;
            end else if (rr_found) begin
                grant_d = 16'(1) << rr_idx;
                last_d  = rr_idx;
                cnt_d   = '0;
            end else begin
                grant_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            grant_q    <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
            last_q     <= 4'd15;
            cnt_q      <= '0;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.HGRANTx      = grant_q;
    assign bus.HMASTER      = master_q;
    assign bus.HMASTLOCK    = mastlock_q;
    assign bus.dbg_last     = last_q;
    assign bus.dbg_hold_cnt = cnt_q;

endmodule

// File: tb/tb_ahb_arbiter16.sv
// Bench for ahb_arbiter16: two instances (MAX_HOLD=1 and 2) share stimulus; a
// behavioural model feeds per-instance expected queues, plus directed checks.
module tb_ahb_arbiter16;

    logic        HCLK = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] req   = '0;
    logic [15:0] lock  = '0;
    logic [15:0] split = '0;
    logic        ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter16_if b1 ();
    ahb_arbiter16_if b2 ();

    assign b1.HBUSREQx = req;
    assign b1.HLOCKx   = lock;
    assign b1.HSPLIT   = split;
    assign b1.HREADY   = ready;
    assign b2.HBUSREQx = req;
    assign b2.HLOCKx   = lock;
    assign b2.HSPLIT   = split;
    assign b2.HREADY   = ready;

    ahb_arbiter16 #(.MAX_HOLD(1)) u_dut1 (.HCLK(HCLK), .HRESETn(rst), .bus(b1));
    ahb_arbiter16 #(.MAX_HOLD(2)) u_dut2 (.HCLK(HCLK), .HRESETn(rst), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_grant  [2];
    logic [3:0]  m_master [2];
    logic        m_lock   [2];
    int          m_last   [2];
    int          m_cnt    [2];

    task automatic model_reset(input int d);
        m_grant[d]  = '0;
        m_master[d] = '0;
        m_lock[d]   = 1'b0;
        m_last[d]   = 15;
        m_cnt[d]    = 0;
    endtask

    task automatic model_step(input int d, input int max_hold);
        int own;
        bit has;
        int pick;
        int j;
        own = 0;
        has = 0;
        pick = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_grant[d][i]) begin
                own = i;
                has = 1;
            end
        end
        m_master[d] = 4'(own);
        m_lock[d]   = has && lock[own];
        if (has && lock[own] && req[own]) begin
            // locked owner keeps the bus, counter frozen
        end else if (has && req[own] && (m_cnt[d] < max_hold - 1)) begin
            m_cnt[d]++;
        end else begin
            for (int k = 1; k <= 16; k++) begin
                j = (m_last[d] + k) % 16;
                if (pick < 0 && req[j] && split[j]) pick = j;
            end
            for (int k = 1; k <= 16; k++) begin
                j = (m_last[d] + k) % 16;
                if (pick < 0 && req[j]) pick = j;
            end
            m_cnt[d] = 0;
            if (pick >= 0) begin
                m_grant[d] = 16'(1) << pick;
                m_last[d]  = pick;
            end else begin
                m_grant[d] = '0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q1[$];
    logic [20:0] exp_q2[$];

    always begin
        logic [20:0] e;
        @(posedge HCLK);
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else if (ready) begin
            model_step(0, 1);
            model_step(1, 2);
        end
        exp_q1.push_back({m_grant[0], m_master[0], m_lock[0]});
        exp_q2.push_back({m_grant[1], m_master[1], m_lock[1]});
        #1;
        e = exp_q1.pop_front();
        chk("sb_dut1", {11'b0, b1.HGRANTx, b1.HMASTER, b1.HMASTLOCK}, {11'b0, e});
        e = exp_q2.pop_front();
        chk("sb_dut2", {11'b0, b2.HGRANTx, b2.HMASTER, b2.HMASTLOCK}, {11'b0, e});
        chk("onehot_dut1", 32'($countones(b1.HGRANTx) <= 1), 32'd1);
        chk("onehot_dut2", 32'($countones(b2.HGRANTx) <= 1), 32'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic edge1();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edge1();
        edge1();
        rst = 1'b0;
    endtask

    initial begin
        // reset with random inputs
        repeat (4) begin
            req   = 16'($urandom);
            lock  = 16'($urandom);
            split = 16'($urandom);
            ready = 1'($urandom_range(0, 1));
            edge1();
        end
        chk("rst_grant", {16'b0, b1.HGRANTx}, 32'h0);
        chk("rst_master", {28'b0, b1.HMASTER}, 32'h0);
        chk("rst_mastlock", {31'b0, b1.HMASTLOCK}, 32'h0);
        chk("rst_last", {28'b0, b1.dbg_last}, 32'd15);
        chk("rst_cnt", {24'b0, b2.dbg_hold_cnt}, 32'd0);
        chk("rst_grant2", {16'b0, b2.HGRANTx}, 32'h0);

        // release with master 0 requesting
        req = 16'h0001; lock = '0; split = '0; ready = 1'b1;
        rst = 1'b0;
        edge1();
        chk("rel_grant", {16'b0, b1.HGRANTx}, 32'h0001);
        edge1();
        chk("rel_master", {28'b0, b1.HMASTER}, 32'h0);
        chk("rel_single_hold", {16'b0, b1.HGRANTx}, 32'h0001);

        // round-robin on MAX_HOLD=1 instance
        req = 16'h8005;
        edge1();
        chk("rr_m2", {16'b0, b1.HGRANTx}, 32'h0004);
        edge1();
        chk("rr_m15", {16'b0, b1.HGRANTx}, 32'h8000);
        edge1();
        chk("rr_m0", {16'b0, b1.HGRANTx}, 32'h0001);

        // HREADY stall with owner m2 and m5 waiting
        req = 16'h0004;
        edge1();
        chk("stall_pre_grant", {16'b0, b1.HGRANTx}, 32'h0004);
        ready = 1'b0;
        req = 16'h0024;
        for (int c = 0; c < 5; c++) begin
            edge1();
            chk("stall_grant", {16'b0, b1.HGRANTx}, 32'h0004);
            chk("stall_master", {28'b0, b1.HMASTER}, 32'h0);
        end
        ready = 1'b1;
        edge1();
        chk("stall_end_grant", {16'b0, b1.HGRANTx}, 32'h0020);
        chk("stall_end_master", {28'b0, b1.HMASTER}, 32'd2);

        // lock on MAX_HOLD=2 instance
        req = 16'h0018; lock = 16'h0008;
        do_reset();
        edge1();
        chk("lock_first", {16'b0, b2.HGRANTx}, 32'h0008);
        for (int c = 2; c <= 12; c++) begin
            edge1();
            chk("lock_grant", {16'b0, b2.HGRANTx}, 32'h0008);
            chk("lock_master", {28'b0, b2.HMASTER}, 32'd3);
            chk("lock_mastlock", {31'b0, b2.HMASTLOCK}, 32'd1);
        end
        req = 16'h0010; lock = '0;
        edge1();
        chk("unlock_grant", {16'b0, b2.HGRANTx}, 32'h0010);
        chk("unlock_mastlock", {31'b0, b2.HMASTLOCK}, 32'd0);

        // split priority with last=0
        req = 16'h0001; lock = '0; split = '0;
        do_reset();
        edge1();
        chk("split_setup", {16'b0, b1.HGRANTx}, 32'h0001);
        req = 16'h0006; split = 16'h0004;
        edge1();
        chk("split_m2_d1", {16'b0, b1.HGRANTx}, 32'h0004);
        chk("split_m2_d2", {16'b0, b2.HGRANTx}, 32'h0004);
        split = '0;
        edge1();
        chk("split_then_m1", {16'b0, b1.HGRANTx}, 32'h0002);

        // idle, then async reset mid-tenure
        req = '0;
        edge1();
        chk("idle_d1", {16'b0, b1.HGRANTx}, 32'h0);
        chk("idle_d2", {16'b0, b2.HGRANTx}, 32'h0);
        req = 16'h0002;
        edge1();
        edge1();
        chk("tenure_master", {28'b0, b1.HMASTER}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_grant", {16'b0, b1.HGRANTx}, 32'h0);
        chk("arst_master", {28'b0, b1.HMASTER}, 32'h0);
        chk("arst_grant2", {16'b0, b2.HGRANTx}, 32'h0);
        edge1();
        rst = 1'b0;

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req   = 16'($urandom) & 16'($urandom);
            lock  = req & 16'($urandom) & 16'($urandom);
            split = 16'($urandom) & 16'($urandom) & 16'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            edge1();
        end

        edge1();
        edge1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter16.md
Name: ahb_arbiter16

Overview:
- Central AMBA AHB bus arbiter for up to 16 masters.
- Samples the per-master request, lock and split-release vectors and issues at most one registered, one-hot grant.
- Drives HMASTER and HMASTLOCK to the address/data multiplexers and slaves.
- Re-arbitration happens only on cycles with HREADY high. Fairness is round-robin, with a per-tenure hold limit and lock support.

Parameters:
- MAX_HOLD, 16: maximum number of consecutive HREADY-high cycles a non-locked owner keeps the grant while others request. Range 1..255.

Ports:
- HCLK  input  1  system clock; all state updates on rising edge.
- HRESETn  input  1  reset, asynchronous, active-high (asserted when 1).
- HBUSREQx  input  16  bit i = master i requests the bus.
- HLOCKx  input  16  bit i = master i requests a locked transfer sequence.
- HGRANTx  output  16  one-hot or all-zero grant, registered.
- HSPLIT  input  16  bit i = a slave signals split release for master i; gives master i priority.
- HREADY  input  1  current transfer completes; arbitration point.
- HMASTER  output  4  index of the master owning the address phase, registered.
- HMASTLOCK  output  1  current address-phase transfer is locked, registered.

Behaviour:
- Reset (HRESETn=1, async) sets:
  - HGRANTx=0, HMASTER=0, HMASTLOCK=0
  - round-robin pointer last=15, so master 0 wins first
  - hold counter=0
- Invariant: $countones(HGRANTx)<=1 in every cycle, including reset and while HRESETn deasserts.
- HREADY=0: all registers hold, including grant, HMASTER, HMASTLOCK, pointer and counter.
- On a rising edge with HREADY=1, all of the following update from the pre-edge values:
  - HMASTER <= index of the current HGRANTx bit, or 0 if HGRANTx==0.
  - HMASTLOCK <= current grant nonzero AND HLOCKx[owner].
  - HGRANTx <= next grant, computed combinationally as follows.
- Next grant, first matching rule wins (owner = currently granted index):
  - Locked hold: owner exists and HLOCKx[owner]&HBUSREQx[owner] -> keep owner. Ignores HSPLIT and MAX_HOLD; counter not incremented.
  - Tenure hold: owner exists, HBUSREQx[owner]=1, and counter<MAX_HOLD-1 -> keep owner; counter++.
  - Split priority: any i with HBUSREQx[i]&HSPLIT[i] -> pick the first such i scanning last+1, last+2, ... mod 16.
  - Round-robin: any HBUSREQx bit set -> pick the first requesting i scanning last+1 ... mod 16. The owner is included, at its natural position after wrap-around.
  - Otherwise, no requests -> HGRANTx=0, counter=0.
- Whenever a new index is chosen (different from the owner, or the owner re-won by the scan): set last=chosen index and counter=0.
- An owner that drops HBUSREQx loses the grant at the next HREADY-high edge. The grant goes to another requester, or to 0 if there are none.
- Single requester: keeps the grant indefinitely, because the scan re-selects it each time the tenure expires.
- Simultaneous lock deassert and HREADY: the lock rule fails, so the remaining rules apply in the same cycle.
- Reset mid-operation: immediate return to reset values, with no partial transfer state retained.
- No latches. Outputs come directly from flops.

Test Plan:
- Reset: HRESETn=1 with random inputs -> HGRANTx=16'h0000, HMASTER=0, HMASTLOCK=0. Release with HBUSREQx=16'h0001, HREADY=1 -> after 1 edge HGRANTx=16'h0001; after 2 edges HMASTER=0.
- Round-robin, MAX_HOLD=1: HBUSREQx=16'h8005, HREADY=1 -> grants in order 0x0001, 0x0004, 0x8000, 0x0001. At most one bit is high throughout.
- HREADY stall: owner m2, HREADY=0 for 5 cycles while m5 requests -> HGRANTx stays 0x0004 and HMASTER is unchanged. The first HREADY=1 edge grants m5, and HMASTER=2 on that edge.
- Lock: m3 holds HBUSREQx and HLOCKx, m4 requests, MAX_HOLD=2 -> m3 is granted for 10+ HREADY cycles and HMASTLOCK=1 with HMASTER=3. Drop HLOCKx[3] and HBUSREQx[3] -> next edge grants 0x0010 and HMASTLOCK becomes 0.
- Split priority: last=0, HBUSREQx=16'h0006, HSPLIT=16'h0004 -> m2 is granted before m1.
- Idle and async reset: all requests drop -> HGRANTx=0 after the next HREADY edge. Assert HRESETn mid-tenure between clock edges -> outputs go to 0 without waiting for HCLK.
